// File: rtl/mul_issue_ctrl.sv
// Execute-stage issue controller for the multi-cycle multiplier: latches operands,
// pulses mult, stalls EX until done, and holds the selected product word until consumed.
module mul_issue_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic [2:0]  es_mul_op,
    input  logic [31:0] es_src1,
    input  logic [31:0] es_src2,
    input  logic        es_flush,
    input  logic        es_ack,
    output logic        es_mul_stall,
    output logic [31:0] mul_result,
    output logic        mul_result_valid,
    output logic        mul_timeout,
    output logic        mult,
    output logic [31:0] x_in,
    output logic [31:0] y_in,
    output logic        signed_op,
    input  logic [63:0] result_out,
    input  logic        done
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          req;
    logic          load;
    logic          capture;
    logic          cnt_inc;
    logic          hi_sel;
    logic [CW-1:0] cnt;

    assign req          = es_valid & (|es_mul_op) & ~es_flush;
    assign es_mul_stall = es_valid & (|es_mul_op) & ~es_flush & (state != HOLD);

    // Next-state and datapath enables
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = es_flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (done && es_flush) begin
                    state_next = IDLE;
                end else if (done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (es_flush) begin
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (es_ack || es_flush) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Counter saturates at TIMEOUT so the sticky flag is set exactly once
        if ((state == WAIT || state == DRAIN) && !done && cnt != CW'(TIMEOUT)) begin
            cnt_inc = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            mult             <= 1'b0;
            mul_result_valid <= 1'b0;
            mul_result       <= '0;
            mul_timeout      <= 1'b0;
            x_in             <= '0;
            y_in             <= '0;
            signed_op        <= 1'b0;
            hi_sel           <= 1'b0;
            cnt              <= '0;
        end else begin
            state            <= state_next;
            mult             <= (state_next == ISSUE);
            mul_result_valid <= (state_next == HOLD);
            if (load) begin
                x_in      <= es_src1;
                y_in      <= es_src2;
                signed_op <= ~es_mul_op[2];
                hi_sel    <= es_mul_op[1] | es_mul_op[2];
            end
            if (capture) begin
                mul_result <= hi_sel ? result_out[2*DW-1:DW] : result_out[DW-1:0];
            end
            if (load) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (cnt_inc && cnt == CW'(TIMEOUT - 1)) begin
                mul_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural multiplier of programmable latency
// and a scoreboard queue of expected product words.
module tb_mul_issue_ctrl;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid;
    logic [2:0]  es_mul_op;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic        es_flush;
    logic        es_ack;
    logic        es_mul_stall;
    logic [31:0] mul_result;
    logic        mul_result_valid;
    logic        mul_timeout;
    logic        mult;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        signed_op;
    logic [63:0] result_out;
    logic        done;
    logic        done_m;
    logic        inj_done;

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          lat = 6;
    bit          done_en = 1'b1;

    mul_issue_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .es_valid(es_valid), .es_mul_op(es_mul_op),
        .es_src1(es_src1), .es_src2(es_src2), .es_flush(es_flush), .es_ack(es_ack),
        .es_mul_stall(es_mul_stall), .mul_result(mul_result),
        .mul_result_valid(mul_result_valid), .mul_timeout(mul_timeout), .mult(mult),
        .x_in(x_in), .y_in(y_in), .signed_op(signed_op), .result_out(result_out),
        .done(done)
    );

    always #5 clk = ~clk;

    assign done = done_m | inj_done;

    function automatic logic [63:0] mprod(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        if (s) return 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Multiplier model: done arrives lat cycles after the cycle in which mult is high
    logic [63:0] prod_m;
    int          cd;
    bit          busy;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done_m     <= 1'b0;
            busy       <= 1'b0;
            cd         <= 0;
            prod_m     <= '0;
            result_out <= '0;
        end else begin
            done_m <= 1'b0;
            if (mult) begin
                if (lat <= 1) begin
                    done_m     <= done_en;
                    result_out <= mprod(x_in, y_in, signed_op);
                    busy       <= 1'b0;
                end else begin
                    busy   <= 1'b1;
                    cd     <= lat - 1;
                    prod_m <= mprod(x_in, y_in, signed_op);
                end
            end else if (busy) begin
                if (cd == 1) begin
                    busy       <= 1'b0;
                    done_m     <= done_en;
                    result_out <= prod_m;
                end
                cd <= cd - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        es_valid  = 1'b1;
        es_mul_op = op;
        es_src1   = a;
        es_src2   = b;
    endtask

    task automatic clr_req();
        es_valid  = 1'b0;
        es_mul_op = 3'b000;
        es_ack    = 1'b0;
        es_flush  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk($sformatf("%s.mult", tag), 32'(mult), 32'd0);
        chk($sformatf("%s.signed_op", tag), 32'(signed_op), 32'd0);
        chk($sformatf("%s.valid", tag), 32'(mul_result_valid), 32'd0);
        chk($sformatf("%s.timeout", tag), 32'(mul_timeout), 32'd0);
        chk($sformatf("%s.x_in", tag), x_in, 32'd0);
        chk($sformatf("%s.y_in", tag), y_in, 32'd0);
        chk($sformatf("%s.result", tag), mul_result, 32'd0);
        chk($sformatf("%s.stall", tag), 32'(es_mul_stall), 32'd0);
    endtask

    // One multiply accepted in the first cycle; done expected at T+1+l, result at T+2+l
    task automatic do_mul(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int l,
                          input int hold);
        logic        exp_s;
        logic [31:0] got;
        exp_s = !op[2];
        lat   = l;
        step();
        set_req(op, a, b);
        exp_q.push_back(exp);
        #1;
        chk($sformatf("%s.stall_T", tag), 32'(es_mul_stall), 32'd1);
        chk($sformatf("%s.mult_T", tag), 32'(mult), 32'd0);
        for (int k = 1; k <= l + 1; k++) begin
            step();
            chk($sformatf("%s.stall_T+%0d", tag, k), 32'(es_mul_stall), 32'd1);
            chk($sformatf("%s.mult_T+%0d", tag, k), 32'(mult), 32'(k == 1));
            chk($sformatf("%s.valid_T+%0d", tag, k), 32'(mul_result_valid), 32'd0);
            if (k == 1) begin
                chk($sformatf("%s.signed_op", tag), 32'(signed_op), 32'(exp_s));
                chk($sformatf("%s.x_in", tag), x_in, a);
                chk($sformatf("%s.y_in", tag), y_in, b);
            end
        end
        step();
        chk($sformatf("%s.valid", tag), 32'(mul_result_valid), 32'd1);
        chk($sformatf("%s.stall_release", tag), 32'(es_mul_stall), 32'd0);
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        chk($sformatf("%s.result", tag), mul_result, got);
        for (int h = 0; h < hold; h++) begin
            step();
            chk($sformatf("%s.hold_valid%0d", tag, h), 32'(mul_result_valid), 32'd1);
            chk($sformatf("%s.hold_result%0d", tag, h), mul_result, got);
        end
        es_ack = 1'b1;
        step();
        clr_req();
        #1;
        chk($sformatf("%s.after_ack", tag), 32'(mul_result_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        inj_done  = 1'b0;
        clr_req();
        es_src1   = '0;
        es_src2   = '0;
        step();
        step();
        chk_reset("reset");
        reset = 1'b0;

        do_mul("mulw", 3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 6, 0);
        do_mul("mulhw", 3'b010, 32'h80000000, 32'h80000000, 32'h40000000, 6, 0);
        do_mul("mulhwu", 3'b100, 32'h80000000, 32'h80000000, 32'h40000000, 6, 0);
        do_mul("mulhw_neg", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 3, 0);
        do_mul("mulhwu_lat1", 3'b100, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1, 0);
        do_mul("hold", 3'b001, 32'h00012345, 32'h00000010, 32'h00123450, 6, 5);

        // Stray done while idle must not produce a result
        step();
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        #1;
        chk("stray.valid", 32'(mul_result_valid), 32'd0);
        chk("stray.mult", 32'(mult), 32'd0);

        // Flush in WAIT at T+3; the next multiply waits for DRAIN to see done at T+7
        lat = 6;
        step();
        set_req(3'b001, 32'd3, 32'd4);
        #1;
        chk("flush.stall_T", 32'(es_mul_stall), 32'd1);
        step();
        step();
        step();
        es_flush = 1'b1;
        #1;
        chk("flush.stall_T+3", 32'(es_mul_stall), 32'd0);
        step();
        es_flush = 1'b0;
        set_req(3'b001, 32'd5, 32'd6);
        #1;
        chk("flush.stall_T+4", 32'(es_mul_stall), 32'd1);
        for (int k = 5; k <= 7; k++) begin
            step();
            chk($sformatf("flush.stall_T+%0d", k), 32'(es_mul_stall), 32'd1);
            chk($sformatf("flush.mult_T+%0d", k), 32'(mult), 32'd0);
            chk($sformatf("flush.valid_T+%0d", k), 32'(mul_result_valid), 32'd0);
        end
        do_mul("after_flush", 3'b001, 32'd5, 32'd6, 32'd30, 6, 0);

        // Flush coincident with done in WAIT discards the product
        lat = 6;
        step();
        set_req(3'b010, 32'h40000000, 32'd4);
        for (int k = 1; k <= 7; k++) step();
        es_flush = 1'b1;
        step();
        clr_req();
        #1;
        chk("flushdone.valid", 32'(mul_result_valid), 32'd0);
        chk("flushdone.mult", 32'(mult), 32'd0);
        do_mul("after_flushdone", 3'b001, 32'd2, 32'd3, 32'd6, 2, 0);

        // Multiplier never answers: sticky timeout, then reset mid-WAIT
        done_en = 1'b0;
        lat     = 6;
        step();
        set_req(3'b010, 32'd1, 32'd1);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("timeout.flag_T+%0d", k), 32'(mul_timeout), 32'(k >= 17));
            chk($sformatf("timeout.stall_T+%0d", k), 32'(es_mul_stall), 32'd1);
        end
        step();
        chk("timeout.sticky", 32'(mul_timeout), 32'd1);
        reset = 1'b1;
        clr_req();
        #1;
        chk_reset("midwait_reset");
        step();
        reset   = 1'b0;
        done_en = 1'b1;

        do_mul("post_reset", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 6, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Execute-stage initiator for the multi-cycle 32x32 Booth/Wallace multiplier. Accepts a decoded `mul.w` / `mulh.w` / `mulh.wu` from the EX stage and drives the multiplier's `mult`/`done` handshake. It stalls the pipeline while the product is computed, selects the low or high 32 bits, and holds the result until the pipeline consumes it. It also absorbs pipeline flushes that arrive mid-operation, so a stale product never reaches writeback.

## Interface
- `TIMEOUT`, default 15: cycles after `mult` with no `done` before `mul_timeout` sets.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `es_valid` input 1: EX stage holds a valid instruction.
- `es_mul_op` input 3: one-hot operation select.
  - [0] `mul.w`: low word, signed.
  - [1] `mulh.w`: high word, signed.
  - [2] `mulh.wu`: high word, unsigned.
  - All-zero means not a multiply.
- `es_src1`, `es_src2` input 32: operands.
- `es_flush` input 1: discard the in-flight multiply (exception/ertn).
- `es_ack` input 1: EX stage advances this cycle and consumes `mul_result`.
- `es_mul_stall` output 1: EX stage must not advance.
- `mul_result` output 32: selected product word.
- `mul_result_valid` output 1: `mul_result` is valid.
- `mul_timeout` output 1: sticky error flag.
- `mult` output 1: start pulse to the multiplier.
- `x_in`, `y_in` output 32: multiplier operands.
- `signed_op` output 1: 1 = signed multiply.
- `result_out` input 64: multiplier product.
- `done` input 1: product valid; a one-cycle pulse.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- **Request:** `req = es_valid & |es_mul_op & ~es_flush`.
- **IDLE:**
  - On `req`, register `es_src1`→`x_in` and `es_src2`→`y_in`.
  - Set `signed_op = ~es_mul_op[2]`. `mul.w` issues signed; its low word is identical for both signednesses.
  - Latch `hi_sel = es_mul_op[1] | es_mul_op[2]`, then go to ISSUE.
- **ISSUE:**
  - `mult = 1` for exactly this cycle; go to WAIT. If `es_flush`, go to DRAIN instead (the multiplier has already sampled `mult`).
- **WAIT:**
  - On `done`, capture `hi_sel ? result_out[63:32] : result_out[31:0]` into `mul_result` and go to HOLD.
  - If `es_flush` arrives with no `done`, go to DRAIN.
  - If `es_flush` and `done` arrive together, discard the product and go to IDLE.
- **HOLD:**
  - `mul_result_valid = 1`.
  - On `es_ack` or `es_flush`, go to IDLE.
- **DRAIN:** wait for `done`, discard the product, go to IDLE. `mul_result_valid` stays 0.
- **Operand stability:** `x_in`, `y_in` and `signed_op` are stable from ISSUE until `done`. They change only in IDLE.
- **Single outstanding multiply:** `mult` is never asserted outside ISSUE, so a second multiply cannot issue before the previous `done`.
- **Stall:** `es_mul_stall = es_valid & |es_mul_op & ~es_flush & (state != HOLD)`.
  - This includes a new multiply seen during DRAIN, which waits for IDLE.
- **Timeout counter:**
  - Cleared on entry to ISSUE; increments in WAIT and DRAIN.
  - When it reaches `TIMEOUT` without `done`, `mul_timeout` sets and stays set until `reset`.
  - The state does not change on timeout.
- **Stray `done`:** `done` seen in IDLE, ISSUE or HOLD is ignored.
- **Reset mid-operation:** all state returns to reset values. The multiplier shares `reset`, so no drain is needed.

## Timing
- **Reset values:** state IDLE; `mult`, `signed_op`, `mul_result_valid`, `mul_timeout` = 0; `x_in`, `y_in`, `mul_result` = 0; `es_mul_stall` is combinational.
- **Nominal sequence for a request accepted in cycle T:**
  - T+1: `mult` high.
  - T+7: `done` high (multiplier latency is 6 cycles from `mult`).
  - T+8: `mul_result_valid` high and `es_mul_stall` low.
  - T..T+7: `es_mul_stall` high, 8 stall cycles.
- **Back-to-back multiplies:** if `es_ack` arrives in T+8, the next multiply is accepted in T+9. Throughput is one multiply per 9 cycles.
- **Latency independence:** the controller must be correct for any `done` latency ≥1 cycle after `mult`; it must not count to 6.

## Test plan
- **`mul.w`:** `es_src1=0x00000007`, `es_src2=0xFFFFFFFD`, request at T → `mult` only at T+1; `mul_result=0xFFFFFFEB` with `mul_result_valid` at T+8; stall high T..T+7.
- **`mulh.w` / `mulh.wu`:** `0x80000000 * 0x80000000`.
  - `mulh.w` → `mul_result=0x40000000`, `signed_op=1`.
  - `mulh.wu` → `mul_result=0x40000000`, `signed_op=0`.
- **Flush in WAIT:** `es_flush` at T+3 → DRAIN; `done` at T+7 is discarded; `mul_result_valid` stays 0; a new `mul.w` presented at T+4 stalls until IDLE, then issues `mult` at T+9.
- **Hold without ack:** `es_ack` held low 5 cycles after result → `mul_result_valid` and `mul_result` stay constant; `es_ack` → IDLE the next cycle.
- **Timeout:** model never asserts `done` → `mul_timeout` = 1 exactly `TIMEOUT` cycles after entering WAIT; stall stays high; `reset` pulse mid-WAIT → all outputs at reset values, `mul_timeout` = 0.
- **Simultaneous flush and done in WAIT:** → IDLE, no `mul_result_valid`; next request issues `mult` 1 cycle after acceptance.
